// File: rtl/count32_pkg.sv
// Shared types and helpers for the count-to-unary expander datapath.
package count32_pkg;

    localparam int N  = 32;
    localparam int CW = $clog2(N + 1);

    typedef logic [N-1:0]  word_t;
    typedef logic [CW-1:0] cnt_t;

    // Counts above N are clamped so the generated word can never overflow.
    function automatic cnt_t sat_count(input cnt_t c);
        return (c > cnt_t'(N)) ? cnt_t'(N) : c;
    endfunction

endpackage

// File: rtl/count32_therm.sv
// Thermometer decoder: bits [n-1:0] set, n=0 gives zero, n=N gives all ones.
// Latency: purely combinational.
// Backpressure: none, stateless.
module count32_therm
    import count32_pkg::*;
(
    input  cnt_t  n,
    output word_t word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < N; i++) begin
            word[i] = (cnt_t'(i) < n);
        end
    end

endmodule

// File: rtl/count32_expand.sv
// Count-to-unary expander: S1 clamp, S2 thermometer, S3 optional rotate (COUNT32_EXPAND_ROTATE_EN).
// Latency: fixed 3 cycles from input transfer to out_valid, plus one per stall cycle.
// Backpressure: single global enable; all stages hold while out_valid && !out_ready.
module count32_expand
    import count32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  cnt_t        in_count,
    output logic        out_valid,
    input  logic        out_ready,
    output word_t       out_word,
    output cnt_t        out_count,
    output logic        out_sat,
    output logic [4:0]  offset
);

    logic  en;
    cnt_t  clamped;
    word_t therm_word;
    word_t rot_word;

    logic  s1_vld_q, s1_vld_d;
    cnt_t  s1_cnt_q, s1_cnt_d;
    logic  s1_sat_q, s1_sat_d;

    logic  s2_vld_q, s2_vld_d;
    word_t s2_word_q, s2_word_d;
    cnt_t  s2_cnt_q, s2_cnt_d;
    logic  s2_sat_q, s2_sat_d;

    logic  out_vld_q, out_vld_d;
    word_t out_word_q, out_word_d;
    cnt_t  out_cnt_q, out_cnt_d;
    logic  out_sat_q, out_sat_d;

    count32_therm u_therm (
        .n    (s1_cnt_q),
        .word (therm_word)
    );

    always_comb begin
        en       = !out_vld_q || out_ready;
        clamped  = sat_count(in_count);

        s1_vld_d   = s1_vld_q;
        s1_cnt_d   = s1_cnt_q;
        s1_sat_d   = s1_sat_q;
        s2_vld_d   = s2_vld_q;
        s2_word_d  = s2_word_q;
        s2_cnt_d   = s2_cnt_q;
        s2_sat_d   = s2_sat_q;
        out_vld_d  = out_vld_q;
        out_word_d = out_word_q;
        out_cnt_d  = out_cnt_q;
        out_sat_d  = out_sat_q;

        // Payload only loads behind a valid so outputs keep their last word across bubbles.
        if (en) begin
            s1_vld_d  = in_valid;
            s2_vld_d  = s1_vld_q;
            out_vld_d = s2_vld_q;
            if (in_valid) begin
                s1_cnt_d = clamped;
                s1_sat_d = (in_count > cnt_t'(N));
            end
            if (s1_vld_q) begin
                s2_word_d = therm_word;
                s2_cnt_d  = s1_cnt_q;
                s2_sat_d  = s1_sat_q;
            end
            if (s2_vld_q) begin
                out_word_d = rot_word;
                out_cnt_d  = s2_cnt_q;
                out_sat_d  = s2_sat_q;
            end
        end
    end

`ifdef COUNT32_EXPAND_ROTATE_EN
    logic [4:0] off_q, off_d;
    logic [4:0] s1_off_q, s1_off_d;
    logic [4:0] s2_off_q, s2_off_d;

    // The pointer travels with its count so the rotation matches the acceptance-time offset.
    always_comb begin
        off_d    = off_q;
        s1_off_d = s1_off_q;
        s2_off_d = s2_off_q;
        if (en && in_valid) begin
            off_d    = off_q + clamped[4:0];
            s1_off_d = off_q;
        end
        if (en && s1_vld_q) begin
            s2_off_d = s1_off_q;
        end
        rot_word = (s2_word_q << s2_off_q) | (s2_word_q >> (N - int'(s2_off_q)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q    <= '0;
            s1_off_q <= '0;
            s2_off_q <= '0;
        end else begin
            off_q    <= off_d;
            s1_off_q <= s1_off_d;
            s2_off_q <= s2_off_d;
        end
    end

    assign offset = off_q;
`else
    assign rot_word = s2_word_q;
    assign offset   = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_cnt_q   <= '0;
            s1_sat_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_word_q  <= '0;
            s2_cnt_q   <= '0;
            s2_sat_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_word_q <= '0;
            out_cnt_q  <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_sat_q   <= s1_sat_d;
            s2_vld_q   <= s2_vld_d;
            s2_word_q  <= s2_word_d;
            s2_cnt_q   <= s2_cnt_d;
            s2_sat_q   <= s2_sat_d;
            out_vld_q  <= out_vld_d;
            out_word_q <= out_word_d;
            out_cnt_q  <= out_cnt_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = out_vld_q;
    assign out_word  = out_word_q;
    assign out_count = out_cnt_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_count32_expand.sv
// Randomized scoreboard bench for count32_expand; follows COUNT32_EXPAND_ROTATE_EN like the design.
module tb_count32_expand;
    import count32_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    cnt_t       in_count;
    logic       out_valid;
    logic       out_ready;
    word_t      out_word;
    cnt_t       out_count;
    logic       out_sat;
    logic [4:0] offset;

    typedef struct {
        word_t word;
        int    cnt;
        bit    sat;
        int    acc_cyc;
        int    stall_snap;
    } exp_t;

    exp_t  sb[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    stall_cnt   = 0;
    int    m_off       = 0;
    bit    rand_ready  = 0;
    bit    stalled     = 0;
    word_t prev_word;
    cnt_t  prev_cnt;
    logic  prev_sat;

    count32_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_count (out_count),
        .out_sat   (out_sat),
        .offset    (offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: n ones laid down starting at the running pointer, then pointer += n.
    always @(negedge clk) begin
        if (rst_n) begin
`ifdef COUNT32_EXPAND_ROTATE_EN
            chk("offset_track", offset, m_off);
`else
            chk("offset_tied", offset, 0);
`endif
            if (in_valid && in_ready) begin
                exp_t e;
                int   n;
                n = (int'(in_count) > 32) ? 32 : int'(in_count);
                e.word = '0;
                for (int i = 0; i < n; i++) begin
`ifdef COUNT32_EXPAND_ROTATE_EN
                    e.word[(m_off + i) % 32] = 1'b1;
`else
                    e.word[i] = 1'b1;
`endif
                end
                e.cnt        = n;
                e.sat        = (int'(in_count) > 32);
                e.acc_cyc    = cyc;
                e.stall_snap = stall_cnt;
                sb.push_back(e);
                m_off = (m_off + n) % 32;
            end
        end
    end

    // Monitor: pops on every output transfer and checks hold-stability across stalls.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_word", out_word, prev_word);
                chk("hold_count", out_count, prev_cnt);
                chk("hold_sat", out_sat, prev_sat);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", out_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_word", out_word, e.word);
                    chk("out_count", out_count, e.cnt);
                    chk("out_sat", out_sat, e.sat);
                    chk("popcount", $countones(out_word), out_count);
                    chk("latency", cyc - e.acc_cyc, 3 + stall_cnt - e.stall_snap);
                end
            end
            stalled   = out_valid && !out_ready;
            prev_word = out_word;
            prev_cnt  = out_count;
            prev_sat  = out_sat;
            if (stalled) stall_cnt++;
        end else begin
            stalled = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input int c);
        in_valid = 1'b1;
        in_count = cnt_t'(c);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("send_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int t = 0; t < 300 && sb.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_offset", offset, 0);
        sb.delete();
        m_off   = 0;
        stalled = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_count  = '0;
        out_ready = 1'b1;
        #17;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("init_in_ready", in_ready, 1);

        send(5);
        drain();

        send(7);
        send(33);
        send(12);
        do_reset();

`ifdef COUNT32_EXPAND_ROTATE_EN
        send(5);
        send(3);
        send(0);
        send(32);
        drain();
        chk("offset_after_seq", offset, 8);
        do_reset();
        send(30);
        send(0);
        drain();
        chk("offset_preload", offset, 30);
        send(4);
        drain();
        chk("offset_wrap", offset, 2);
        send(40);
        drain();
        chk("offset_after_sat", offset, 2);
`else
        send(32);
        send(0);
        send(40);
        drain();
        chk("offset_plain", offset, 0);
`endif

        for (int i = 0; i < 4; i++) send($urandom_range(0, 32));
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send($urandom_range(0, 40));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
